stream_demux_1ton: RTL and testbench

Parametrised successor to the combinational 1-to-2 demultiplexer: routes a valid/ready data stream from one input to one of N output channels, with packet-locked channel selection, a single registered output stage, and an optional round-robin mode. It sits between a single producer and several consumers wherever one source fans out to multiple sinks without data loss under backpressure.

---
 rtl/stream_demux_pkg.sv | 15 +
 rtl/stream_demux_if.sv | 30 +++
 rtl/demux_out_reg.sv | 60 ++++++
 rtl/stream_demux_1ton.sv | 114 +++++++++++
 tb/tb_stream_demux_1ton.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Holds the packet FSM state encoding and the channel range check.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  function automatic logic ch_in_range(input int ch, input int n_out);
    return ch < n_out;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the demux input stream, per-channel output streams and status.
// slave = demux side, master = producer/consumer side.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
);
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_last;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_last;
  logic [N_OUT-1:0]        out_ready;
  logic                    sel_err;
  logic                    busy;

  modport slave (
    input  in_data, in_valid, in_last, in_sel, out_ready,
    output in_ready, out_data, out_valid, out_last, sel_err, busy
  );

  modport master (
    output in_data, in_valid, in_last, in_sel, out_ready,
    input  in_ready, out_data, out_valid, out_last, sel_err, busy
  );
endinterface

// File: rtl/demux_out_reg.sv
// Single-beat output register: holds data, last flag and target channel.
// A load in the same cycle as a drain wins, so the register stays full.
module demux_out_reg #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [CH_W-1:0]   load_ch,
  output logic              buf_valid,
  output logic [DATA_W-1:0] buf_data,
  output logic              buf_last,
  output logic [CH_W-1:0]   buf_ch
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    ch_d    = ch_q;
    if (drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
      ch_d    = load_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_data  = data_q;
  assign buf_last  = last_q;
  assign buf_ch    = ch_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Routes one valid/ready stream to one of N_OUT channels, channel locked per packet.
// Packet FSM, round-robin pointer and one-hot output decode live here.
module stream_demux_1ton #(
  parameter int DATA_W  = 8,
  parameter int N_OUT   = 4,
  parameter int RR_MODE = 0
) (
  input logic           clk,
  input logic           rst_n,
  stream_demux_if.slave bus
);
  import stream_demux_pkg::*;

  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic              sel_err_q, sel_err_d;
  logic [SEL_W-1:0]  pick_ch;
  logic              accept;
  logic              load;
  logic              drain;

  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              buf_last;
  logic [SEL_W-1:0]  buf_ch;

  // Only the locked channel's sink can stall the register.
  assign drain        = buf_valid & bus.out_ready[buf_ch];
  assign bus.in_ready = (state_q == DROP) | ~buf_valid | drain;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pick_ch      = (RR_MODE != 0) ? rr_q : bus.in_sel;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    sel_err_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ch_in_range(int'(pick_ch), N_OUT)) begin
            load = 1'b1;
            ch_d = pick_ch;
            if (!bus.in_last) state_d = ROUTE;
          end else begin
            sel_err_d = 1'b1;
            if (!bus.in_last) state_d = DROP;
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          load = 1'b1;
          if (bus.in_last) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && bus.in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((RR_MODE != 0) && accept && bus.in_last) begin
      rr_d = (rr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      rr_q      <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      sel_err_q <= sel_err_d;
    end
  end

  demux_out_reg #(
    .DATA_W (DATA_W),
    .CH_W   (SEL_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .drain     (drain),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .load_ch   (ch_d),
    .buf_valid (buf_valid),
    .buf_data  (buf_data),
    .buf_last  (buf_last),
    .buf_ch    (buf_ch)
  );

  // Data and last are gated so idle channels always read zero.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic hit;
    assign hit                                 = buf_valid && (buf_ch == SEL_W'(gi));
    assign bus.out_valid[gi]                   = hit;
    assign bus.out_last[gi]                    = hit & buf_last;
    assign bus.out_data[gi*DATA_W +: DATA_W]   = hit ? buf_data : '0;
  end

  assign bus.sel_err = sel_err_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: vector table and corner sequences on N_OUT=4,
// round-robin instance, and a randomized scoreboard run on an N_OUT=3 instance.
module tb_stream_demux_1ton;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .N_OUT(4)) if4 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(3)) if3 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(4)) ifr ();

  stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .RR_MODE(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave));
  stream_demux_1ton #(.DATA_W(8), .N_OUT(3), .RR_MODE(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .RR_MODE(1)) u_dutr (
    .clk(clk), .rst_n(rst_n), .bus(ifr.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic        lst;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [3:0]  exp_ol;
    logic [31:0] exp_od;
    logic        exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic lst, input logic [1:0] sel,
                              input logic [7:0] dat, input logic [3:0] ordy, input logic rdy,
                              input logic [3:0] ov, input logic [3:0] ol, input logic [31:0] od,
                              input logic bsy);
    vec_t v;
    v.vld = vld; v.lst = lst; v.sel = sel; v.dat = dat; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_ol = ol; v.exp_od = od; v.exp_busy = bsy;
    return v;
  endfunction

  typedef struct packed {
    logic [1:0] ch;
    logic       lst;
    logic [7:0] dat;
  } beat_t;

  vec_t  vecs[18];
  beat_t expq[$];

  initial begin
    // Directed vectors for the N_OUT=4 instance.
    vecs[0]  = mk(1'b1, 1'b0, 2'd2, 8'hA1, 4'hF,    1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 2'd0, 8'hA2, 4'hF,    1'b1, 4'b0100, 4'b0000, 32'h00A2_0000, 1'b1);
    vecs[2]  = mk(1'b1, 1'b1, 2'd0, 8'hA3, 4'hF,    1'b1, 4'b0100, 4'b0100, 32'h00A3_0000, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'hF,    1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 2'd0, 8'h11, 4'hF,    1'b1, 4'b0001, 4'b0001, 32'h0000_0011, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 2'd3, 8'h33, 4'hF,    1'b1, 4'b1000, 4'b1000, 32'h3300_0000, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'hF,    1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 2'd1, 8'h55, 4'hF,    1'b1, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[8]  = mk(1'b1, 1'b1, 2'd1, 8'h56, 4'b1101, 1'b0, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 2'd1, 8'h56, 4'b0000, 1'b0, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[10] = mk(1'b1, 1'b1, 2'd2, 8'h56, 4'b1101, 1'b0, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[11] = mk(1'b1, 1'b1, 2'd1, 8'h56, 4'b1101, 1'b0, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[12] = mk(1'b1, 1'b1, 2'd1, 8'h56, 4'b1101, 1'b0, 4'b0010, 4'b0000, 32'h0000_5500, 1'b1);
    vecs[13] = mk(1'b1, 1'b1, 2'd1, 8'h56, 4'b0010, 1'b1, 4'b0010, 4'b0010, 32'h0000_5600, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 2'd2, 8'h77, 4'b0000, 1'b1, 4'b0100, 4'b0100, 32'h0077_0000, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0100, 4'b0100, 32'h0077_0000, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0);

    if4.in_valid = 1'b0; if4.in_last = 1'b0; if4.in_sel = '0; if4.in_data = '0; if4.out_ready = '1;
    if3.in_valid = 1'b0; if3.in_last = 1'b0; if3.in_sel = '0; if3.in_data = '0; if3.out_ready = '1;
    ifr.in_valid = 1'b0; ifr.in_last = 1'b0; ifr.in_sel = '0; ifr.in_data = '0; ifr.out_ready = '1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(if4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if4.out_valid), 64'd0);
    chk("rst_out_data", 64'(if4.out_data), 64'd0);
    chk("rst_busy", 64'(if4.busy), 64'd0);
    chk("rst_sel_err", 64'(if4.sel_err), 64'd0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if4.in_valid = vecs[i].vld; if4.in_last = vecs[i].lst; if4.in_sel = vecs[i].sel;
      if4.in_data = vecs[i].dat; if4.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(if4.in_ready), 64'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), 64'(if4.out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_last", i), 64'(if4.out_last), 64'(vecs[i].exp_ol));
      chk($sformatf("vec%0d_out_data", i), 64'(if4.out_data), 64'(vecs[i].exp_od));
      chk($sformatf("vec%0d_busy", i), 64'(if4.busy), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_sel_err", i), 64'(if4.sel_err), 64'd0);
      $display("vec %0d: in v=%0b l=%0b sel=%0d d=%02h ordy=%04b -> ov=%04b od=%08h", i,
               vecs[i].vld, vecs[i].lst, vecs[i].sel, vecs[i].dat, vecs[i].ordy,
               if4.out_valid, if4.out_data);
    end
    @(negedge clk);
    if4.in_valid = 1'b0; if4.out_ready = '1;

    // ---- round-robin: five single-beat packets ----
    for (int i = 0; i < 5; i++) begin
      int unsigned exp_ch;
      exp_ch = i % 4;
      @(negedge clk);
      ifr.in_valid = 1'b1; ifr.in_last = 1'b1; ifr.in_sel = 2'($urandom_range(0, 3));
      ifr.in_data = 8'(8'h10 + i);
      #1;
      chk($sformatf("rr%0d_in_ready", i), 64'(ifr.in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_out_valid", i), 64'(ifr.out_valid), 64'(4'b0001 << exp_ch));
      chk($sformatf("rr%0d_out_data", i), 64'(ifr.out_data), 64'(32'(8'h10 + i) << (8 * exp_ch)));
      $display("rr packet %0d: data=%02h -> out_valid=%04b", i, 8'h10 + i, ifr.out_valid);
    end
    @(negedge clk);
    ifr.in_valid = 1'b0;

    // ---- out-of-range select on N_OUT=3 ----
    @(negedge clk);
    if3.in_valid = 1'b1; if3.in_last = 1'b0; if3.in_sel = 2'd3; if3.in_data = 8'hE1;
    #1;
    chk("drop0_in_ready", 64'(if3.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("drop0_sel_err", 64'(if3.sel_err), 64'd1);
    chk("drop0_out_valid", 64'(if3.out_valid), 64'd0);
    chk("drop0_busy", 64'(if3.busy), 64'd1);
    @(negedge clk);
    if3.in_last = 1'b1; if3.in_sel = 2'd0; if3.in_data = 8'hE2;
    #1;
    chk("drop1_in_ready", 64'(if3.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("drop1_sel_err", 64'(if3.sel_err), 64'd0);
    chk("drop1_out_valid", 64'(if3.out_valid), 64'd0);
    chk("drop1_busy", 64'(if3.busy), 64'd0);
    @(negedge clk);
    if3.in_last = 1'b1; if3.in_sel = 2'd0; if3.in_data = 8'h42;
    @(posedge clk); #1;
    chk("after_drop_out_valid", 64'(if3.out_valid), 64'b001);
    chk("after_drop_out_data", 64'(if3.out_data), 64'h42);
    chk("after_drop_sel_err", 64'(if3.sel_err), 64'd0);
    $display("sel_err sequence: dropped 2-beat packet, next packet on out_valid=%03b", if3.out_valid);
    @(negedge clk);
    if3.in_valid = 1'b0;

    // ---- reset in the middle of a stalled packet ----
    @(negedge clk);
    if4.in_valid = 1'b1; if4.in_last = 1'b0; if4.in_sel = 2'd1; if4.in_data = 8'h99;
    if4.out_ready = 4'b0000;
    @(posedge clk); #1;
    chk("prerst_out_valid", 64'(if4.out_valid), 64'b0010);
    chk("prerst_busy", 64'(if4.busy), 64'd1);
    @(negedge clk);
    if4.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(if4.out_valid), 64'd0);
    chk("midrst_out_last", 64'(if4.out_last), 64'd0);
    chk("midrst_out_data", 64'(if4.out_data), 64'd0);
    chk("midrst_busy", 64'(if4.busy), 64'd0);
    chk("midrst_in_ready", 64'(if4.in_ready), 64'd1);
    chk("midrst_rr_out_valid", 64'(ifr.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if4.out_ready = '1;
    @(negedge clk);
    if4.in_valid = 1'b1; if4.in_last = 1'b1; if4.in_sel = 2'd2; if4.in_data = 8'hB0;
    ifr.in_valid = 1'b1; ifr.in_last = 1'b1; ifr.in_sel = 2'd3; ifr.in_data = 8'hC0;
    @(posedge clk); #1;
    chk("postrst_out_valid", 64'(if4.out_valid), 64'b0100);
    chk("postrst_out_data", 64'(if4.out_data), 64'h00B0_0000);
    chk("postrst_rr_out_valid", 64'(ifr.out_valid), 64'b0001);
    chk("postrst_rr_out_data", 64'(ifr.out_data), 64'hC0);
    $display("post-reset: dut4 out_valid=%04b rr out_valid=%04b", if4.out_valid, ifr.out_valid);
    @(negedge clk);
    if4.in_valid = 1'b0; ifr.in_valid = 1'b0;

    // ---- randomized run on N_OUT=3 against a packet-level scoreboard ----
    begin
      logic       drv_v, drv_l, m_in_pkt, m_drop, m_err_pend, exp_rdy, prev_hold;
      logic [7:0] drv_d;
      logic [1:0] drv_s, m_ch;
      logic [2:0] ov, ordy, prev_ov, prev_ol;
      logic [23:0] od, stray, prev_od;
      int left;
      beat_t got, want;
      drv_v = 1'b0; drv_l = 1'b0; drv_d = '0; drv_s = '0; left = 0;
      m_in_pkt = 1'b0; m_drop = 1'b0; m_err_pend = 1'b0; m_ch = '0;
      prev_hold = 1'b0; prev_ov = '0; prev_ol = '0; prev_od = '0;
      for (int cyc = 0; cyc < 420; cyc++) begin
        @(negedge clk);
        if (!drv_v && cyc < 380 && $urandom_range(0, 3) != 0) begin
          if (left == 0) begin
            left  = int'($urandom_range(1, 4));
            drv_s = 2'($urandom_range(0, 3));
          end else begin
            drv_s = 2'($urandom_range(0, 3));
          end
          drv_d = 8'($urandom);
          drv_l = (left == 1);
          drv_v = 1'b1;
        end
        ordy = (cyc >= 380) ? 3'b111 : 3'($urandom);
        if3.in_valid = drv_v; if3.in_last = drv_l; if3.in_sel = drv_s; if3.in_data = drv_d;
        if3.out_ready = ordy;
        #1;
        ov = if3.out_valid; od = if3.out_data;
        chk("rnd_busy", 64'(if3.busy), 64'(m_in_pkt));
        chk("rnd_sel_err", 64'(if3.sel_err), 64'(m_err_pend));
        chk("rnd_onehot", 64'($onehot0(ov)), 64'd1);
        exp_rdy = (m_in_pkt && m_drop) || (ov == 3'b000) || ((ov & ordy) != 3'b000);
        chk("rnd_in_ready", 64'(if3.in_ready), 64'(exp_rdy));
        if (prev_hold) begin
          chk("rnd_hold", 64'({ov, if3.out_last, od}), 64'({prev_ov, prev_ol, prev_od}));
        end
        stray = od;
        for (int k = 0; k < 3; k++) if (ov[k]) stray[k*8 +: 8] = 8'h00;
        chk("rnd_idle_data_zero", 64'(stray), 64'd0);
        for (int k = 0; k < 3; k++) begin
          if (ov[k] && ordy[k]) begin
            got = {2'(k), if3.out_last[k], od[k*8 +: 8]};
            if (expq.size() == 0) begin
              chk("rnd_unexpected_beat", 64'(got), 64'h3FF);
            end else begin
              want = expq.pop_front();
              chk("rnd_beat", 64'(got), 64'(want));
              $display("beat out: ch=%0d data=%02h last=%0b", k, od[k*8 +: 8], if3.out_last[k]);
            end
          end
        end
        prev_hold = (ov != 3'b000) && ((ov & ordy) == 3'b000);
        prev_ov = ov; prev_ol = if3.out_last; prev_od = od;
        m_err_pend = 1'b0;
        if (drv_v && if3.in_ready) begin
          if (!m_in_pkt) begin
            m_ch       = drv_s;
            m_drop     = (drv_s >= 2'd3);
            m_err_pend = m_drop;
          end
          if (!m_drop) expq.push_back({m_ch, drv_l, drv_d});
          m_in_pkt = !drv_l;
          drv_v = 1'b0;
          left--;
        end
      end
      chk("rnd_all_delivered", 64'(expq.size()), 64'd0);
      if3.in_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
